io_periph_hub: RTL and testbench
================================

// Module: io_periph_hub
// PURPOSE
//  Parametrised memory-mapped I/O hub for the single-cycle MIPS system. Replaces the fixed
//  io_sel / seg7 / switch-mux trio with one block: window decode, N-digit scanned 7-seg
//  display, synchronised + debounced switch port, and a programmable down-counter timer
//  driving the CPU intr/inta interrupt handshake. Sits beside dmem on the CPU data bus.
// PARAMETERS
//  IO_BASE     32'h1002_0000  base of 256-byte I/O window (addr[31:8] compared)
//  SW_WIDTH    16             switch inputs, zero-extended to 32 bits on read
//  DIGITS      8              7-seg digits scanned (1..16); digits >= 8 are blank
//  SCAN_DIV    50000          clk cycles per digit in scan rotation (>= 2)
//  DEB_CYCLES  100000         cycles a synced switch value must stay stable (>= 2)
// PORTS
//  clk      in   1         system clock (CPU clock), all state on rising edge
//  reset    in   1         asynchronous, active-low reset
//  addr     in   32        CPU data address
//  wdata    in   32        CPU store data
//  cs       in   1         data-bus chip select from CPU (DM_CS)
//  we       in   1         store strobe
//  re       in   1         load strobe
//  rdata    out  32        load data, combinational; 0 when no read hit
//  io_hit   out  1         addr inside I/O window (comb.); top muxes rdata vs dmem
//  sw       in   SW_WIDTH  raw asynchronous switches
//  o_seg    out  8         segments {dp,g,f,e,d,c,b,a}, active-low, registered
//  o_sel    out  DIGITS    digit enables, one-hot active-low, registered
//  intr     out  1         interrupt request to CPU
//  inta     in   1         interrupt acknowledge from CPU (1-cycle pulse)
// BEHAVIOUR
//  Map (word offset): 0x00 SEG RW | 0x04 SW RO | 0x08 TLOAD RW | 0x0C TCTRL RW
//   {bit0 en, bit1 auto-reload, bit2 irq_en, others read 0} | 0x10 TCOUNT RO |
//   0x14 ISTAT bit0 timer-expired, write-1-to-clear. Other offsets: read 0, writes dropped.
//  Write when cs&we&io_hit at rising clk; byte offset addr[1:0] ignored. Read data valid
//   same cycle when cs&re&io_hit, else rdata=0. Writes to RO registers ignored.
//  Reset (reset=0): all registers 0, scan idx 0, o_sel=~1 (digit0 on), o_seg=8'hC0 ('0'),
//   intr=0, debounced SW=0, debounce and scan counters 0.
//  Switches: 2-flop sync; if sync!=stable count++, else count=0; when count==DEB_CYCLES-1
//   stable<=sync, count<=0. Change visible at SW after DEB_CYCLES+2 cycles; glitch shorter
//   than DEB_CYCLES never visible.
//  Display: scan counter 0..SCAN_DIV-1; on wrap idx<=(idx==DIGITS-1)?0:idx+1. Digit i shows
//   hex nibble SEG[4i+3:4i] (standard 0-F patterns, dp=1 off); i>=8 drives 8'hFF.
//   o_seg/o_sel update together one cycle after idx changes; never two digits enabled.
//  Timer: write TLOAD sets TLOAD and TCOUNT=wdata. While en and TCOUNT!=0: TCOUNT-- each
//   cycle. On TCOUNT==1 with en: ISTAT[0]<=1; TCOUNT<=auto-reload ? TLOAD : 0. One-shot
//   stops at 0; TLOAD=0 never fires. en=0 freezes TCOUNT. Period = TLOAD cycles.
//  Same-cycle collisions: TLOAD write beats decrement/reload for TCOUNT (expiry flag
//   still sets); set of ISTAT[0] beats W1C and inta clear.
//  intr = ISTAT[0] & TCTRL[2] (from registers, glitch-free). inta=1 clears ISTAT[0];
//   inta with ISTAT[0]=0 has no effect.
//  Async reset mid-count/mid-scan: everything returns to reset values immediately.
// TESTING
//  1 Reset: hold reset=0 -> rdata 0 all offsets, o_sel=8'hFE, o_seg=8'hC0, intr=0.
//  2 SEG=32'h0000_00A5, SCAN_DIV=4 -> digit0 8'h92 ('5'), digit1 8'h88 ('A'), digit2
//     8'hC0; o_sel rotates FE,FD,..,7F,FE every 4 cycles.
//  3 DEB_CYCLES=8: sw=16'h0001 held 10 cycles -> SW reads 1 at cycle 10; 5-cycle pulse
//     -> SW stays 0.
//  4 TLOAD=5, TCTRL=3'b111 -> intr rises 5 cycles after en, TCOUNT reloads 5; inta pulse
//     -> intr 0, re-asserts 5 cycles later.
//  5 One-shot TLOAD=3, TCTRL=3'b101 -> single expiry, TCOUNT holds 0; W1C on expiry
//     cycle -> ISTAT[0] stays 1.
//  6 addr=IO_BASE+0x100 or 0x1001_0000 -> io_hit=0, rdata=0, no register written.

Source files
------------

// File: rtl/io_periph_hub_if.sv
// CPU data-bus view of the I/O hub: address/data/strobes from the CPU,
// combinational load data and window-hit flag back to the CPU-side mux.
interface io_periph_hub_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cs;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        io_hit;

    modport master (
        output addr, wdata, cs, we, re,
        input  rdata, io_hit
    );

    modport slave (
        input  addr, wdata, cs, we, re,
        output rdata, io_hit
    );
endinterface

// File: rtl/io_periph_hub.sv
// Memory-mapped I/O hub: window decode, scanned hex 7-seg display, debounced
// switch port and a down-counter timer driving the intr/inta handshake.
module io_periph_hub #(
    parameter logic [31:0] IO_BASE    = 32'h1002_0000,
    parameter int unsigned SW_WIDTH   = 16,
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    io_periph_hub_if.slave      bus,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [7:0]          o_seg,
    output logic [DIGITS-1:0]   o_sel,
    output logic                intr,
    input  logic                inta
);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);

    logic [31:0]         r_seg_data;
    logic [31:0]         r_tload;
    logic [31:0]         r_tcount;
    logic [2:0]          r_tctrl;
    logic                r_istat;
    logic [SW_WIDTH-1:0] r_sw_meta;
    logic [SW_WIDTH-1:0] r_sw_sync;
    logic [SW_WIDTH-1:0] r_sw_stable;
    logic [DEB_W-1:0]    r_deb_cnt;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [3:0]          r_idx;
    logic [7:0]          r_seg_drv;
    logic [DIGITS-1:0]   r_sel_drv;

    logic       w_hit;
    logic [7:0] w_off;
    logic       w_wr;
    logic       w_rd;
    logic       w_expire;
    logic [3:0] w_nib;
    logic [7:0] w_pat;

    // Byte-lane bits are masked so any byte address selects the whole word.
    assign w_hit      = (bus.addr[31:8] == IO_BASE[31:8]);
    assign w_off      = bus.addr[7:0] & 8'hFC;
    assign w_wr       = bus.cs & bus.we & w_hit;
    assign w_rd       = bus.cs & bus.re & w_hit;
    assign w_expire   = r_tctrl[0] && (r_tcount == 32'd1);
    assign bus.io_hit = w_hit;
    assign intr       = r_istat & r_tctrl[2];
    assign o_seg      = r_seg_drv;
    assign o_sel      = r_sel_drv;

    always_comb begin
        bus.rdata = '0;
        if (w_rd) begin
            case (w_off)
                8'h00:   bus.rdata = r_seg_data;
                8'h04:   bus.rdata = 32'(r_sw_stable);
                8'h08:   bus.rdata = r_tload;
                8'h0C:   bus.rdata = {29'd0, r_tctrl};
                8'h10:   bus.rdata = r_tcount;
                8'h14:   bus.rdata = {31'd0, r_istat};
                default: bus.rdata = '0;
            endcase
        end
    end

    always_comb begin
        w_nib = r_seg_data[{r_idx[2:0], 2'b00} +: 4];
        case (w_nib)
            4'h0: w_pat = 8'hC0;
            4'h1: w_pat = 8'hF9;
            4'h2: w_pat = 8'hA4;
            4'h3: w_pat = 8'hB0;
            4'h4: w_pat = 8'h99;
            4'h5: w_pat = 8'h92;
            4'h6: w_pat = 8'h82;
            4'h7: w_pat = 8'hF8;
            4'h8: w_pat = 8'h80;
            4'h9: w_pat = 8'h90;
            4'hA: w_pat = 8'h88;
            4'hB: w_pat = 8'h83;
            4'hC: w_pat = 8'hC6;
            4'hD: w_pat = 8'hA1;
            4'hE: w_pat = 8'h86;
            default: w_pat = 8'h8E;
        endcase
        if (r_idx[3]) w_pat = 8'hFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_meta   <= '0;
            r_sw_sync   <= '0;
            r_sw_stable <= '0;
            r_deb_cnt   <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (r_sw_sync == r_sw_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                r_sw_stable <= r_sw_sync;
                r_deb_cnt   <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    // Drivers are registered from the current index, so they trail idx by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_seg_drv  <= 8'hC0;
            r_sel_drv  <= ~DIGITS'(1);
        end else begin
            if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == 4'(DIGITS - 1)) ? 4'd0 : r_idx + 4'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
            r_seg_drv <= w_pat;
            r_sel_drv <= ~(DIGITS'(1) << r_idx);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg_data <= '0;
            r_tload    <= '0;
            r_tcount   <= '0;
            r_tctrl    <= '0;
            r_istat    <= 1'b0;
        end else begin
            if (w_wr && w_off == 8'h00) r_seg_data <= bus.wdata;
            if (w_wr && w_off == 8'h0C) r_tctrl    <= bus.wdata[2:0];
            // A TLOAD store overrides the count, but an expiry in the same cycle still flags.
            if (w_wr && w_off == 8'h08) begin
                r_tload  <= bus.wdata;
                r_tcount <= bus.wdata;
            end else if (r_tctrl[0] && r_tcount != '0) begin
                if (w_expire) r_tcount <= r_tctrl[1] ? r_tload : '0;
                else          r_tcount <= r_tcount - 32'd1;
            end
            if (w_expire) begin
                r_istat <= 1'b1;
            end else if ((w_wr && w_off == 8'h14 && bus.wdata[0]) || inta) begin
                r_istat <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_io_periph_hub.sv
// Self-checking bench for io_periph_hub: register-map vectors, scan display,
// debounce timing, timer/interrupt handshake and asynchronous reset.
module tb_io_periph_hub;
    localparam logic [31:0] B    = 32'h1002_0000;
    localparam int unsigned SCAN = 4;
    localparam int unsigned DEB  = 8;
    localparam int unsigned NV   = 23;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic        hit;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sw    = '0;
    logic        inta  = 1'b0;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;
    logic        intr;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    logic [7:0] pat [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    io_periph_hub_if bus ();

    io_periph_hub #(
        .IO_BASE(B), .SW_WIDTH(16), .DIGITS(8), .SCAN_DIV(SCAN), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .sw(sw),
        .o_seg(o_seg), .o_sel(o_sel), .intr(intr), .inta(inta)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time bound expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.cs = 1'b1; bus.we = 1'b1;
        tick(1);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        bus.addr = a; bus.cs = 1'b1; bus.re = 1'b1;
        #1;
        d = bus.rdata;
        h = bus.io_hit;
        bus.cs = 1'b0; bus.re = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        bus_read(a, d, h);
        check(name, d, exp);
    endtask

    // Watches the scan for n cycles: one digit lit, left rotation, SCAN-cycle dwell, hex glyphs.
    task automatic check_scan(input logic [31:0] v, input int unsigned n);
        logic [7:0]  prev;
        logic [7:0]  cur;
        int unsigned run;
        int unsigned dig;
        bit          first;
        prev = o_sel; run = 1; first = 1'b1;
        for (int unsigned c = 0; c < n; c++) begin
            tick(1);
            cur = o_sel;
            check("sel_onehot", 32'($onehot(~cur)), 32'd1);
            dig = 0;
            for (int unsigned k = 0; k < 8; k++) if (!cur[k]) dig = k;
            check($sformatf("seg_digit%0d", dig), o_seg, pat[int'((v >> (4 * dig)) & 32'hF)]);
            if (cur != prev) begin
                check("sel_rotate", cur, {prev[6:0], prev[7]});
                if (!first) check("scan_dwell", run, SCAN);
                first = 1'b0;
                run   = 1;
            end else begin
                run++;
            end
            prev = cur;
        end
    endtask

    task automatic timer_idle();
        bus_write(B + 32'h0C, 32'd0);
        bus_write(B + 32'h14, 32'd1);
        read_chk("istat_cleared", B + 32'h14, 32'd0);
    endtask

    // Expiries fall on multiples of L (auto-reload) or only at L (one-shot).
    task automatic run_timer(input int unsigned L, input bit auto_rl, input int unsigned n,
                             input int unsigned ack_t);
        bit          istat_m;
        logic [31:0] exp_cnt;
        bit          expired;
        bus_write(B + 32'h08, L);
        bus_write(B + 32'h0C, {29'd0, 1'b1, auto_rl, 1'b1});
        istat_m = 1'b0;
        for (int unsigned t = 1; t <= n; t++) begin
            if (t == ack_t) inta = 1'b1;
            tick(1);
            inta = 1'b0;
            expired = auto_rl ? (t % L == 0) : (t == L);
            if (expired) istat_m = 1'b1;
            else if (t == ack_t) istat_m = 1'b0;
            exp_cnt = auto_rl ? 32'(L - (t % L)) : ((t < L) ? 32'(L - t) : 32'd0);
            check($sformatf("intr_L%0d_t%0d", L, t), intr, istat_m);
            read_chk($sformatf("tcount_L%0d_t%0d", L, t), B + 32'h10, exp_cnt);
        end
        timer_idle();
    endtask

    initial begin
        vec_t        vecs [NV];
        logic [31:0] d;
        logic        h;
        logic [15:0] prev_sw;
        logic [15:0] v;

        bus.addr = '0; bus.wdata = '0; bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0;

        vecs = '{
            '{1'b0, B + 32'h00,   32'h0,         32'h0,         1'b1},
            '{1'b0, B + 32'h14,   32'h0,         32'h0,         1'b1},
            '{1'b0, B + 32'h1C,   32'h0,         32'h0,         1'b1},
            '{1'b0, 32'h1001_0000, 32'h0,        32'h0,         1'b0},
            '{1'b0, B + 32'h100,  32'h0,         32'h0,         1'b0},
            '{1'b1, B + 32'h00,   32'hDEAD_BEEF, 32'h0,         1'b1},
            '{1'b0, B + 32'h00,   32'h0,         32'hDEAD_BEEF, 1'b1},
            '{1'b0, B + 32'h03,   32'h0,         32'hDEAD_BEEF, 1'b1},
            '{1'b1, B + 32'h0A,   32'h0000_1234, 32'h0,         1'b1},
            '{1'b0, B + 32'h08,   32'h0,         32'h0000_1234, 1'b1},
            '{1'b0, B + 32'h10,   32'h0,         32'h0000_1234, 1'b1},
            '{1'b1, B + 32'h10,   32'h0000_0055, 32'h0,         1'b1},
            '{1'b0, B + 32'h10,   32'h0,         32'h0000_1234, 1'b1},
            '{1'b1, B + 32'h0C,   32'hFFFF_FFF6, 32'h0,         1'b1},
            '{1'b0, B + 32'h0C,   32'h0,         32'h0000_0006, 1'b1},
            '{1'b1, B + 32'h04,   32'h0000_FFFF, 32'h0,         1'b1},
            '{1'b0, B + 32'h04,   32'h0,         32'h0,         1'b1},
            '{1'b1, B + 32'h100,  32'h0000_1111, 32'h0,         1'b0},
            '{1'b0, B + 32'h00,   32'h0,         32'hDEAD_BEEF, 1'b1},
            '{1'b1, 32'h1001_0008, 32'h0000_0009, 32'h0,        1'b0},
            '{1'b0, B + 32'h08,   32'h0,         32'h0000_1234, 1'b1},
            '{1'b1, B + 32'h18,   32'h0000_0007, 32'h0,         1'b1},
            '{1'b0, B + 32'h18,   32'h0,         32'h0,         1'b1}
        };

        // Reset held low
        tick(3);
        check("rst_o_sel", o_sel, 8'hFE);
        check("rst_o_seg", o_seg, 8'hC0);
        check("rst_intr", intr, 1'b0);
        for (int unsigned off = 0; off < 32; off += 4) begin
            read_chk($sformatf("rst_rd_%02h", off), B + off, 32'd0);
            tick(1);
        end
        reset = 1'b1;
        tick(1);

        // Register map vectors
        for (int i = 0; i < int'(NV); i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, d, h);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
                check($sformatf("vec%0d_hit", i), h, vecs[i].hit);
                tick(1);
            end
        end
        bus.addr = B; bus.cs = 1'b0; bus.re = 1'b1;
        #1;
        check("rdata_no_cs", bus.rdata, 32'd0);
        bus.re = 1'b0;
        bus_write(B + 32'h0C, 32'd0);

        // Display
        bus_write(B, 32'h0000_00A5);
        check_scan(32'h0000_00A5, 40);
        for (int r = 0; r < 3; r++) begin
            d = $urandom;
            bus_write(B, d);
            check_scan(d, 36);
        end

        // Debounce
        sw = 16'h0001;
        tick(DEB + 1);
        read_chk("sw_before_deb", B + 32'h04, 32'd0);
        tick(1);
        read_chk("sw_after_deb", B + 32'h04, 32'd1);
        sw = 16'h0000;
        tick(DEB + 4);
        read_chk("sw_back_zero", B + 32'h04, 32'd0);
        sw = 16'h0001; tick(5); sw = 16'h0000;
        for (int c = 0; c < 14; c++) begin
            tick(1);
            read_chk("sw_glitch5", B + 32'h04, 32'd0);
        end
        sw = 16'h0001; tick(DEB - 1); sw = 16'h0000;
        for (int c = 0; c < 14; c++) begin
            tick(1);
            read_chk("sw_glitch7", B + 32'h04, 32'd0);
        end
        prev_sw = 16'h0000;
        for (int r = 0; r < 3; r++) begin
            v = 16'($urandom_range(1, 65535));
            if (v == prev_sw) v = ~prev_sw;
            sw = v;
            tick(DEB + 1);
            read_chk("sw_rand_old", B + 32'h04, 32'(prev_sw));
            tick(1);
            read_chk("sw_rand_new", B + 32'h04, 32'(v));
            prev_sw = v;
        end

        // Timer: auto-reload with ack, ack colliding with expiry, one-shot
        run_timer(5, 1'b1, 16, 6);
        run_timer(4, 1'b1, 10, 8);
        run_timer(3, 1'b0, 8, 0);

        // W1C on the expiry cycle loses to the set
        bus_write(B + 32'h08, 32'd3);
        bus_write(B + 32'h0C, 32'd5);
        tick(2);
        bus_write(B + 32'h14, 32'd1);
        check("w1c_collide_intr", intr, 1'b1);
        read_chk("w1c_collide_istat", B + 32'h14, 32'd1);
        read_chk("oneshot_tcount", B + 32'h10, 32'd0);
        tick(4);
        read_chk("oneshot_hold", B + 32'h10, 32'd0);
        bus_write(B + 32'h14, 32'd1);
        check("w1c_clear_intr", intr, 1'b0);
        timer_idle();

        // TLOAD store on the expiry cycle wins the count; irq_en off masks intr
        bus_write(B + 32'h08, 32'd4);
        bus_write(B + 32'h0C, 32'd3);
        tick(3);
        bus_write(B + 32'h08, 32'd9);
        read_chk("tload_collide_cnt", B + 32'h10, 32'd9);
        read_chk("tload_collide_istat", B + 32'h14, 32'd1);
        check("intr_masked", intr, 1'b0);
        tick(1);
        read_chk("tload_collide_next", B + 32'h10, 32'd8);
        timer_idle();

        // TLOAD=0 never fires
        bus_write(B + 32'h08, 32'd0);
        bus_write(B + 32'h0C, 32'd7);
        tick(10);
        check("tload0_intr", intr, 1'b0);
        read_chk("tload0_istat", B + 32'h14, 32'd0);
        timer_idle();

        // en=0 freezes the count
        bus_write(B + 32'h08, 32'd20);
        bus_write(B + 32'h0C, 32'd1);
        tick(3);
        bus_write(B + 32'h0C, 32'd0);
        tick(5);
        read_chk("freeze_cnt", B + 32'h10, 32'd16);

        for (int r = 0; r < 6; r++) begin
            int unsigned L;
            int unsigned n;
            L = $urandom_range(1, 7);
            n = 3 * L + 3;
            run_timer(L, 1'($urandom_range(0, 1)), n, $urandom_range(1, n));
        end

        // Asynchronous reset mid-count / mid-scan
        bus_write(B, 32'h1234_5678);
        bus_write(B + 32'h08, 32'd3);
        bus_write(B + 32'h0C, 32'd7);
        tick(4);
        check("pre_reset_intr", intr, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_intr", intr, 1'b0);
        check("async_rst_sel", o_sel, 8'hFE);
        check("async_rst_seg", o_seg, 8'hC0);
        read_chk("async_rst_tcount", B + 32'h10, 32'd0);
        read_chk("async_rst_seg_reg", B, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(2);
        check("post_rst_sel", o_sel, 8'hFE);
        check("post_rst_intr", intr, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
